// File: rtl/gpr_file_pkg.sv
// Shared constants and helpers for the MIPS general-purpose register file.
// Build option: GPR_PARITY_EN adds per-entry even parity and a sticky error flag.
package gpr_file_pkg;

    localparam int REG_DATA_W   = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;

    localparam logic [REG_DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic RST_ACTIVE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    function automatic logic even_parity(input logic [REG_DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One decode-stage read port: $0 hardwiring, WB bypass and array lookup.
// Build option: GPR_PARITY_EN adds a parity check on genuine array reads.
module gpr_read_port
    import gpr_file_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] arr_data,
`ifdef GPR_PARITY_EN
    input  logic              arr_par,
    output logic              par_bad,
`endif
    output logic [DATA_W-1:0] rdata
);

    logic bypass;
    logic array_read;

    assign bypass     = (re == READ_ENABLE) && (we == WRITE_ENABLE) && (raddr == waddr);
    assign array_read = (rst != RST_ACTIVE) && (raddr != '0) && (re == READ_ENABLE) && !bypass;

    // Priority: reset, $0, bypass, array, disabled.
    always_comb begin
        rdata = '0;
        if (rst == RST_ACTIVE) begin
            rdata = '0;
        end else if (raddr == '0) begin
            rdata = '0;
        end else if (bypass) begin
            rdata = wdata;
        end else if (re == READ_ENABLE) begin
            rdata = arr_data;
        end else begin
            rdata = '0;
        end
    end

`ifdef GPR_PARITY_EN
    assign par_bad = array_read && ((^arr_data) != arr_par);
`else
    logic unused_array_read;
    assign unused_array_read = array_read;
`endif

endmodule

// File: rtl/gpr_file.sv
// 32x32 general-purpose register file: two combinational read ports, one write port.
// Build option: GPR_PARITY_EN stores even parity per entry and reports the first failure.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
`ifdef GPR_PARITY_EN
    ,
    output logic              parity_err_o,
    output logic [ADDR_W-1:0] parity_err_addr_o
`endif
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if ((we == WRITE_ENABLE) && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef GPR_PARITY_EN
    logic par_bits [NUM_REGS];
    logic par_bad1;
    logic par_bad2;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                par_bits[i] <= 1'b0;
            end
        end else if ((we == WRITE_ENABLE) && (waddr != '0)) begin
            par_bits[waddr] <= ^wdata;
        end
    end

    // First failure wins and holds until reset; port 1 beats port 2.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            parity_err_o      <= 1'b0;
            parity_err_addr_o <= '0;
        end else if (!parity_err_o && (par_bad1 || par_bad2)) begin
            parity_err_o      <= 1'b1;
            parity_err_addr_o <= par_bad1 ? raddr1 : raddr2;
        end
    end
`endif

    gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (
        .rst      (rst),
        .re       (re1),
        .raddr    (raddr1),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .arr_data (regs[raddr1]),
`ifdef GPR_PARITY_EN
        .arr_par  (par_bits[raddr1]),
        .par_bad  (par_bad1),
`endif
        .rdata    (rdata1)
    );

    gpr_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (
        .rst      (rst),
        .re       (re2),
        .raddr    (raddr2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .arr_data (regs[raddr2]),
`ifdef GPR_PARITY_EN
        .arr_par  (par_bits[raddr2]),
        .par_bad  (par_bad2),
`endif
        .rdata    (rdata2)
    );

endmodule
